mul_seq: RTL



---
 rtl/mul_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/mul_seq.sv
// Sequential unsigned shift-add multiplier: one multiplier bit retired per cycle,
// 2W-bit product presented with a single-cycle valid_r pulse after W+1 cycles.
module mul_seq #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pass,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy_r,
    output logic             valid_r,
    output logic [2*W-1:0]   p_r
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [W-1:0]    a_r, a_s;
    logic [W-1:0]    b_r, b_s;
    logic [2*W-1:0]  acc_r, acc_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            valid_s;
    logic [2*W-1:0]  partial_s;

    // busy is the state bit itself, so it stays a pure flop output
    assign busy_r = (state_r == RUN);
    assign p_r    = acc_r;

    // Shifted multiplicand contributed by the current multiplier bit
    always_comb begin
        partial_s = {(2*W){1'b0}};
        if (b_r[0]) begin
            partial_s = {{W{1'b0}}, a_r} << cnt_r;
        end else begin
            partial_s = {(2*W){1'b0}};
        end
    end

    // Next-state and datapath update; pass restarts from any state
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        valid_s = 1'b0;
        if (pass) begin
            state_s = RUN;
            a_s     = a;
            b_s     = b;
            acc_s   = {(2*W){1'b0}};
            cnt_s   = {CW{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    acc_s = acc_r + partial_s;
                    b_s   = b_r >> 1;
                    cnt_s = cnt_r + CW'(1);
                    if (cnt_r == LAST) begin
                        state_s = IDLE;
                        valid_s = 1'b1;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        state_s = RUN;
                    end
                end
                IDLE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            acc_r   <= {(2*W){1'b0}};
            cnt_r   <= {CW{1'b0}};
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
        end else begin
            state_r <= state_s;
            valid_r <= valid_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
        end
    end

endmodule
